// File: rtl/uart_pkg.sv
// Shared state encoding and frame constants for the UART frame sequencer.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_LABEL,
        ST_GET_PIXELS,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    localparam logic [7:0] HDR_INFER     = 8'hA5;
    localparam logic [7:0] HDR_TRAIN     = 8'h5A;
    localparam int         IMG_BYTES_DEF = 784;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte idle counter: expires after TIMEOUT_CYC enabled cycles without a clear.
module uart_byte_timeout #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire
);

    localparam int               TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] r_tmr;

    // A byte arriving on the terminal cycle wins over the expiry.
    assign o_expire = i_en && !i_clr && (r_tmr == TMR_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr <= '0;
        end else if (i_clr || !i_en || o_expire) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + TMR_W'(1);
        end
    end

endmodule

// File: rtl/uart_frame_sequencer.sv
// Parses header/label/pixel frames from the byte receiver and holds a start request until the core is done.
module uart_frame_sequencer #(
    parameter int          IMG_BYTES   = uart_pkg::IMG_BYTES_DEF,
    parameter int          TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0]  HDR_INFER   = uart_pkg::HDR_INFER,
    parameter logic [7:0]  HDR_TRAIN   = uart_pkg::HDR_TRAIN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    input  logic                       core_done,
    output logic                       start,
    output logic                       train,
    output logic [7:0]                 label,
    output logic [(IMG_BYTES<<3)-1:0]  image,
    output logic                       busy,
    output logic                       frame_err
);

    import uart_pkg::*;

    localparam int IMG_SZ = IMG_BYTES << 3;
    localparam int CNT_W  = $clog2(IMG_BYTES);
    localparam int SLOT_W = CNT_W + 3;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_err;
    logic                w_expire;
    logic                w_receiving;
    logic                w_last_pix;
    logic [CNT_W-1:0]    r_cnt;
    logic [SLOT_W-1:0]   w_slot_msb;
    logic                r_start;
    logic                r_train;
    logic [7:0]          r_label;
    logic [IMG_SZ-1:0]   r_image;
    logic                r_busy;
    logic                r_frame_err;

    assign w_receiving = (r_state == ST_GET_LABEL) || (r_state == ST_GET_PIXELS);
    assign w_last_pix  = (r_cnt == CNT_W'(IMG_BYTES - 1));
    assign w_slot_msb  = SLOT_W'(IMG_SZ - 1) - {r_cnt, 3'b000};

    uart_byte_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_receiving),
        .i_clr    (rx_valid),
        .o_expire (w_expire)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == HDR_INFER || rx_data == HDR_TRAIN) w_state_nxt = ST_GET_LABEL;
                    else                                               w_err       = 1'b1;
                end
            end
            ST_GET_LABEL: begin
                if (rx_valid)      w_state_nxt = ST_GET_PIXELS;
                else if (w_expire) begin w_state_nxt = ST_IDLE; w_err = 1'b1; end
            end
            ST_GET_PIXELS: begin
                if (rx_valid) begin
                    if (w_last_pix) w_state_nxt = ST_ISSUE;
                end else if (w_expire) begin
                    w_state_nxt = ST_IDLE;
                    w_err       = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (core_done) w_state_nxt = ST_DRAIN;
                if (rx_valid)  w_err       = 1'b1;
            end
            ST_DRAIN: begin
                // Wait for done to drop so a stale level cannot retrigger the next frame.
                if (!core_done) w_state_nxt = ST_IDLE;
                if (rx_valid)   w_err       = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the image register is reset because it is a visible output with a defined reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_start     <= 1'b0;
            r_train     <= 1'b0;
            r_label     <= '0;
            r_image     <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_err <= w_err;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_start     <= (w_state_nxt == ST_ISSUE);
            if (rx_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (rx_data == HDR_INFER)      r_train <= 1'b0;
                        else if (rx_data == HDR_TRAIN) r_train <= 1'b1;
                    end
                    ST_GET_LABEL: begin
                        r_label <= rx_data;
                        r_cnt   <= '0;
                    end
                    ST_GET_PIXELS: begin
                        r_image[w_slot_msb -: 8] <= rx_data;
                        if (!w_last_pix) r_cnt <= r_cnt + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
            if (w_expire) r_cnt <= '0;
        end
    end

    assign start     = r_start;
    assign train     = r_train;
    assign label     = r_label;
    assign image     = r_image;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Directed self-checking bench for uart_frame_sequencer (short timeout so the abort path is reachable).
module tb_uart_frame_sequencer;

    localparam int IMG_BYTES   = 784;
    localparam int IMG_SZ      = IMG_BYTES << 3;
    localparam int TIMEOUT_CYC = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              core_done;
    logic              start;
    logic              train;
    logic [7:0]        label;
    logic [IMG_SZ-1:0] image;
    logic              busy;
    logic              frame_err;

    int n_checks = 0;
    int n_errors = 0;

    uart_frame_sequencer #(
        .IMG_BYTES   (IMG_BYTES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .core_done (core_done),
        .start     (start),
        .train     (train),
        .label     (label),
        .image     (image),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    function automatic logic [7:0] pix(input int sel, input int k);
        case (sel)
            0:       return 8'(k);
            1:       return 8'(255 - k);
            default: return 8'(k) ^ 8'h55;
        endcase
    endfunction

    task automatic send_pixels(input int sel, input int first, input int last);
        for (int k = first; k <= last; k++) send_byte(pix(sel, k));
    endtask

    function automatic logic [7:0] img_byte(input int k);
        return image[IMG_SZ-1-8*k -: 8];
    endfunction

    initial begin
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        core_done = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 1: asynchronous reset in the middle of a training frame
        send_byte(8'h5A);
        send_byte(8'h33);
        send_pixels(0, 0, 4);
        check("t1_busy_mid_frame", busy, 1);
        check("t1_train_mid_frame", train, 1);
        rst_n = 1'b0;
        #1;
        check("t1_rst_busy", busy, 0);
        check("t1_rst_start", start, 0);
        check("t1_rst_train", train, 0);
        check("t1_rst_label", label, 0);
        check("t1_rst_err", frame_err, 0);
        check("t1_rst_image", 32'(|image), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t1_idle_after_rst", busy, 0);

        // 2: inference frame, full done handshake
        send_byte(8'hA5);
        send_byte(8'h07);
        send_pixels(0, 0, IMG_BYTES - 2);
        check("t2_start_before_last", start, 0);
        send_pixels(0, IMG_BYTES - 1, IMG_BYTES - 1);
        check("t2_start", start, 1);
        check("t2_train", train, 0);
        check("t2_label", label, 8'h07);
        check("t2_img0", img_byte(0), 8'h00);
        check("t2_img300", img_byte(300), 8'h2C);
        check("t2_img783", img_byte(783), 8'h0F);
        check("t2_err", frame_err, 0);
        repeat (3) tick();
        check("t2_start_held", start, 1);
        core_done = 1'b1;
        tick();
        check("t2_start_drop", start, 0);
        check("t2_busy_drain", busy, 1);
        tick();
        check("t2_busy_drain_hold", busy, 1);
        core_done = 1'b0;
        tick();
        check("t2_busy_idle", busy, 0);

        // 3: training frame with an overrun byte during ISSUE
        send_byte(8'h5A);
        send_byte(8'h03);
        send_pixels(1, 0, IMG_BYTES - 1);
        check("t3_start", start, 1);
        check("t3_train", train, 1);
        check("t3_label", label, 8'h03);
        send_byte(8'hEE);
        check("t3_overrun_err", frame_err, 1);
        check("t3_start_kept", start, 1);
        check("t3_img0", img_byte(0), 8'hFF);
        check("t3_img783", img_byte(783), 8'hF0);
        tick();
        check("t3_err_one_cycle", frame_err, 0);
        check("t3_label_frozen", label, 8'h03);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        check("t3_busy_idle", busy, 0);

        // 4: bad header, then a valid header is accepted
        send_byte(8'h00);
        check("t4_bad_hdr_err", frame_err, 1);
        check("t4_bad_hdr_busy", busy, 0);
        tick();
        check("t4_err_one_cycle", frame_err, 0);
        send_byte(8'hA5);
        check("t4_hdr_accepted", busy, 1);

        // 5: label + 10 pixels, then silence until the timeout aborts the frame
        send_byte(8'h01);
        send_pixels(2, 0, 9);
        for (int i = 1; i <= TIMEOUT_CYC; i++) begin
            tick();
            check($sformatf("t5_err_c%0d", i), frame_err, (i == TIMEOUT_CYC) ? 1 : 0);
            check($sformatf("t5_busy_c%0d", i), busy, (i == TIMEOUT_CYC) ? 0 : 1);
            check($sformatf("t5_start_c%0d", i), start, 0);
        end
        tick();
        check("t5_err_one_cycle", frame_err, 0);
        check("t5_partial_label", label, 8'h01);

        // 5b: next frame; a byte on the terminal timeout cycle wins
        send_byte(8'hA5);
        send_byte(8'h09);
        repeat (TIMEOUT_CYC - 1) tick();
        send_pixels(2, 0, 0);
        check("t5b_byte_wins_err", frame_err, 0);
        check("t5b_byte_wins_busy", busy, 1);
        send_pixels(2, 1, IMG_BYTES - 1);
        check("t5b_start", start, 1);
        check("t5b_label", label, 8'h09);
        check("t5b_img0", img_byte(0), 8'h55);
        check("t5b_img9", img_byte(9), 8'h5C);
        check("t5b_img783", img_byte(783), 8'h5A);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        check("t5b_busy_idle", busy, 0);

        // 6: core_done already high when ISSUE is entered
        send_byte(8'hA5);
        send_byte(8'h44);
        send_pixels(0, 0, IMG_BYTES - 2);
        core_done = 1'b1;
        send_pixels(0, IMG_BYTES - 1, IMG_BYTES - 1);
        check("t6_start_cycle1", start, 1);
        tick();
        check("t6_start_cycle2", start, 0);
        check("t6_busy_drain", busy, 1);
        repeat (4) tick();
        check("t6_drain_held", busy, 1);
        check("t6_start_stays_low", start, 0);
        core_done = 1'b0;
        tick();
        check("t6_busy_idle", busy, 0);
        check("t6_err", frame_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
